// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: FIFO-queued command sequencer driving a downstream I2C master, one command in flight.
// Optional NACK relaunch is enabled by defining I2C_SEQ_RETRY_EN.
module i2c_cmd_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 200000,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [6:0]                    cmd_addr,
    input  logic                          cmd_rw,
    input  logic [7:0]                    cmd_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_data,
    output logic [1:0]                    rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          m_start,
    output logic [6:0]                    m_addr,
    output logic [7:0]                    m_data_in,
    output logic                          m_rw,
    input  logic                          m_busy,
    input  logic                          m_ack_error,
    input  logic [7:0]                    m_data_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_RESP      = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_RETRY > 255) begin : g_param_check
        $error("i2c_cmd_seq: FIFO_DEPTH must be a power of 2 >= 2 and MAX_RETRY <= 255");
    end

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_m_q, busy_s_q;
    logic [1:0]    state_q, state_d;
    logic          m_start_q, m_start_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic          m_rw_q, m_rw_d;
    logic [7:0]    m_data_q, m_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic          push, pop, tmo_hit;
`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    // Pointer difference (with wrap bit) is the occupancy, so level tracks push/pop exactly.
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign push       = cmd_valid && cmd_ready_q;
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        pop         = 1'b0;
        state_d     = state_q;
        m_start_d   = m_start_q;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_data_d    = m_data_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef I2C_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fifo_level != '0) begin
                    pop                          = 1'b1;
                    {m_addr_d, m_rw_d, m_data_d} = fifo_mem[rd_ptr_q[AW-1:0]];
                    tmo_d                        = '0;
                    m_start_d                    = 1'b1;
                    state_d                      = S_LAUNCH;
`ifdef I2C_SEQ_RETRY_EN
                    retry_d                      = '0;
`endif
                end
            end
            S_LAUNCH, S_WAIT_DONE: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_hit) begin
                    m_start_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 2'b10;
                    state_d     = S_RESP;
                end else if (state_q == S_LAUNCH) begin
                    if (busy_s_q) begin
                        m_start_d = 1'b0;
                        state_d   = S_WAIT_DONE;
                    end
                end else if (!busy_s_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (m_rw_q && !m_ack_error) ? m_data_out : '0;
                    rsp_err_d   = m_ack_error ? 2'b01 : 2'b00;
                    state_d     = S_RESP;
`ifdef I2C_SEQ_RETRY_EN
                    if (m_ack_error && (retry_q < RW'(MAX_RETRY))) begin
                        rsp_valid_d = 1'b0;
                        rsp_data_d  = rsp_data_q;
                        rsp_err_d   = rsp_err_q;
                        retry_d     = retry_q + RW'(1);
                        tmo_d       = '0;
                        m_start_d   = 1'b1;
                        state_d     = S_LAUNCH;
                    end
`endif
                end
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
        wr_ptr_d    = wr_ptr_q + LW'(push);
        rd_ptr_d    = rd_ptr_q + LW'(pop);
        cmd_ready_d = (wr_ptr_d - rd_ptr_d) != LW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_addr, cmd_rw, cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_ready_q <= 1'b0;
            busy_m_q    <= 1'b0;
            busy_s_q    <= 1'b0;
            state_q     <= S_IDLE;
            m_start_q   <= 1'b0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_data_q    <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_m_q    <= m_busy;
            busy_s_q    <= busy_m_q;
            state_q     <= state_d;
            m_start_q   <= m_start_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_data_q    <= m_data_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign m_start   = m_start_q;
    assign m_addr    = m_addr_q;
    assign m_rw      = m_rw_q;
    assign m_data_in = m_data_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed self-checking bench for i2c_cmd_seq with a simple busy/ack I2C master model.
module tb_i2c_cmd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic [2:0] fifo_level;
    logic       m_start, m_rw, m_busy, m_ack_error;
    logic [6:0] m_addr;
    logic [7:0] m_data_in, m_data_out;

    i2c_cmd_seq #(.FIFO_DEPTH(4), .TIMEOUT(1000), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .fifo_level(fifo_level),
        .m_start(m_start), .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw),
        .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: busy for 6 cycles per start, returns addr ^ slv_key as read data.
    logic       slv_en, slv_nack, start_prev, valid_at_fall;
    logic [7:0] slv_key;
    int         starts = 0, busy_cnt = 0, rise_cyc = 0, fall_cyc = 0;
    logic [6:0] last_addr;
    logic       last_rw;
    logic [7:0] last_data;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_ack_error = 1'b0; m_data_out = '0;
            busy_cnt = 0; start_prev = 1'b0;
        end else begin
            if (m_start && !start_prev) begin
                starts++; rise_cyc = cyc;
                last_addr = m_addr; last_rw = m_rw; last_data = m_data_in;
            end
            if (!m_start && start_prev) begin
                fall_cyc = cyc; valid_at_fall = rsp_valid;
            end
            start_prev = m_start;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    m_busy = 1'b0; m_ack_error = slv_nack;
                    m_data_out = {1'b0, m_addr} ^ slv_key;
                end
            end else if (m_start && slv_en) begin
                m_busy = 1'b1; busy_cnt = 6; m_ack_error = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_data = d;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check("push_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [7:0] exp_d, input logic [1:0] exp_e);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_seen"}, n < 3000, 1);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_err"}, rsp_err, exp_e);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int s0, n, seen;
        cmd_valid = 0; cmd_addr = '0; cmd_rw = 0; cmd_data = '0; rsp_ready = 0;
        slv_en = 1; slv_nack = 0; slv_key = 8'h77;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_m_start", m_start, 0);
        check("rst_level", fifo_level, 0);
        check("rst_m_addr", m_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);

        // Write: data byte on the bus, response data forced to zero
        s0 = starts;
        push(7'h50, 1'b0, 8'hA5);
        get_rsp("wr", 8'h00, 2'b00);
        check("wr_starts", starts - s0, 1);
        check("wr_addr", last_addr, 7'h50);
        check("wr_rw", last_rw, 0);
        check("wr_data_in", last_data, 8'hA5);

        // Read: 0x68 ^ 0x54 = 0x3C
        slv_key = 8'h54;
        push(7'h68, 1'b1, 8'h00);
        get_rsp("rd", 8'h3C, 2'b00);
        check("rd_rw", last_rw, 1);

        // FIFO fill with response stalled, then in-order drain
        push(7'h11, 1'b1, 8'h00);
        push(7'h22, 1'b1, 8'h00);
        push(7'h33, 1'b1, 8'h00);
        push(7'h44, 1'b1, 8'h00);
        push(7'h55, 1'b1, 8'h00);
        n = 0;
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        check("fifo_rsp_seen", n < 3000, 1);
        check("fifo_level_full", fifo_level, 4);
        check("fifo_cmd_ready_low", cmd_ready, 0);
        repeat (5) @(negedge clk);
        check("fifo_hold_valid", rsp_valid, 1);
        check("fifo_hold_data", rsp_data, 8'h45);
        get_rsp("drain0", 8'h45, 2'b00);
        get_rsp("drain1", 8'h76, 2'b00);
        get_rsp("drain2", 8'h67, 2'b00);
        get_rsp("drain3", 8'h10, 2'b00);
        get_rsp("drain4", 8'h01, 2'b00);
        check("drain_level", fifo_level, 0);

        // NACK on a read: data zeroed, attempts depend on retry build
        slv_nack = 1'b1;
        s0 = starts;
        push(7'h2A, 1'b1, 8'h00);
        get_rsp("nack", 8'h00, 2'b01);
`ifdef I2C_SEQ_RETRY_EN
        check("nack_attempts", starts - s0, 3);
`else
        check("nack_attempts", starts - s0, 1);
`endif
        slv_nack = 1'b0;

        // Timeout with master never busy
        slv_en = 1'b0;
        push(7'h10, 1'b0, 8'h5A);
        get_rsp("tmo", 8'h00, 2'b10);
        check("tmo_cycles", fall_cyc - rise_cyc, 1000);
        check("tmo_valid_at_drop", valid_at_fall, 1);
        slv_en = 1'b1;

        // Reset during WAIT_DONE with two commands queued
        s0 = starts;
        push(7'h21, 1'b0, 8'h01);
        push(7'h22, 1'b1, 8'h02);
        push(7'h23, 1'b0, 8'h03);
        n = 0;
        while (!(starts != s0 && !m_start) && n < 200) begin @(negedge clk); n++; end
        check("rstmid_wait_done", n < 200, 1);
        check("rstmid_level_before", fifo_level, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_rsp_data", rsp_data, 0);
        check("rstmid_rsp_err", rsp_err, 0);
        check("rstmid_m_start", m_start, 0);
        check("rstmid_m_addr", m_addr, 0);
        check("rstmid_m_rw", m_rw, 0);
        check("rstmid_m_data_in", m_data_in, 0);
        check("rstmid_level", fifo_level, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid || m_start) seen++;
        end
        check("rstmid_no_activity", seen, 0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        check("rstmid_level_after", fifo_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_seq.md
I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries; power of 2, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 200000: clk cycles allowed per transfer attempt before abort.
REQ-003 SHALL have parameter MAX_RETRY, default 2: NACK relaunches per command; used only with I2C_SEQ_RETRY_EN.
REQ-004 clk  input  1  system clock (100 MHz).
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO can accept a command.
REQ-008 cmd_addr  input  7  7-bit target address.
REQ-009 cmd_rw  input  1  0 = write, 1 = read.
REQ-010 cmd_data  input  8  write byte; ignored for reads.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed.
REQ-013 rsp_data  output  8  read byte; 0x00 for writes and errors.
REQ-014 rsp_err  output  2  00 ok, 01 NACK, 10 timeout.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  queued command count.
REQ-016 m_start, m_addr[6:0], m_data_in[7:0], m_rw  output  drive the downstream I2C master's start/addr/data_in/rw.
REQ-017 m_busy, m_ack_error, m_data_out[7:0]  input  status and read data from the downstream I2C master.

Function
REQ-018 Push SHALL occur on cmd_valid && cmd_ready; cmd_ready = !full, registered, never combinationally dependent on a same-cycle pop.
REQ-019 FIFO SHALL use wrapping read/write pointers with an extra wrap bit; full = level==FIFO_DEPTH, empty = level==0; level updates by +1 on push, -1 on pop, unchanged when both occur.
REQ-020 m_busy SHALL pass through a 2-flop synchronizer (busy_s) before FSM use, because the master updates it on its slow internal clock.
REQ-021 FSM states: IDLE, LAUNCH, WAIT_DONE, RESP.
REQ-022 IDLE: if FIFO non-empty, SHALL pop the head into m_addr/m_rw/m_data_in, clear the timeout counter, and go to LAUNCH next cycle.
REQ-023 LAUNCH: SHALL hold m_start=1 until busy_s==1, then drop m_start and go to WAIT_DONE.
REQ-024 WAIT_DONE: on busy_s==0, SHALL capture m_ack_error and m_data_out, then go to RESP (or relaunch per REQ-032).
REQ-025 m_addr, m_rw and m_data_in SHALL stay stable from LAUNCH entry until RESP entry.
REQ-026 Timeout counter SHALL increment every cycle in LAUNCH and WAIT_DONE; reaching TIMEOUT SHALL force m_start=0 and rsp_err=10, then go to RESP.
REQ-027 RESP: rsp_valid=1 with rsp_data/rsp_err held constant until rsp_ready; on the handshake, go to IDLE next cycle.
REQ-028 rsp_data SHALL equal the captured m_data_out only when m_rw==1 and rsp_err==00; otherwise 0x00.
REQ-029 Commands SHALL complete strictly in FIFO order; at most one command in flight.

Reset
REQ-030 On rst: FSM=IDLE, pointers=0, fifo_level=0, cmd_ready=1 one cycle after release, rsp_valid=0, rsp_data=0, rsp_err=00, m_start=0, m_addr=0, m_rw=0, m_data_in=0, synchronizer=0, counters=0.
REQ-031 Reset asserted mid-transfer SHALL discard the in-flight and queued commands with no response issued.

Configuration
REQ-032 Macro I2C_SEQ_RETRY_EN: when defined, a NACK in WAIT_DONE SHALL relaunch (back to LAUNCH, timeout counter cleared) up to MAX_RETRY times before reporting rsp_err=01; when undefined, a NACK SHALL report rsp_err=01 immediately, and no retry counter SHALL exist.

Verification
REQ-033 Write 0x50/0xA5 with ACKing slave model -> one m_start pulse train, m_addr=0x50, m_rw=0, m_data_in=0xA5; response rsp_err=00, rsp_data=0x00.
REQ-034 Read from 0x68, slave returns 0x3C -> rsp_err=00, rsp_data=0x3C.
REQ-035 Push 5 commands with rsp_ready=0, FIFO_DEPTH=4 -> cmd_ready low once level reaches 4 with one command held in RESP; responses drain in push order once rsp_ready=1.
REQ-036 Address NACK -> rsp_err=01 after 1 attempt without macro; after 3 attempts (MAX_RETRY=2) with macro.
REQ-037 m_busy tied 0, TIMEOUT=1000 -> m_start drops and rsp_err=10 exactly 1000 cycles after LAUNCH entry.
REQ-038 rst asserted during WAIT_DONE with 2 queued commands -> all outputs at reset values, fifo_level=0, no response.
